// File: rtl/xdma_grant_manager_mc_if.sv
// Grant handshake bundle between the XDMA grant manager and the previous hop.
interface xdma_grant_manager_mc_if #(
  parameter int unsigned ChanIdWidth = 2
);
  logic                   grant_valid_o;
  logic [ChanIdWidth-1:0] grant_chan_o;
  logic                   grant_ready_i;

  modport master (output grant_valid_o, output grant_chan_o, input grant_ready_i);
  modport slave  (input grant_valid_o, input grant_chan_o, output grant_ready_i);
endinterface

// File: rtl/xdma_grant_manager_mc.sv
// Multi-channel XDMA grant manager: per-channel grant FSMs sharing one locked round-robin grant port.
// Optional stall timeout flags enabled by defining XDMA_GRANT_TIMEOUT_EN.
module xdma_grant_manager_mc #(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned GrantCntWidth = 8,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned ChanIdWidth  = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumChannels-1:0]             dma_type_i,
  input  logic [NumChannels-1:0]             is_first_cw_i,
  input  logic [NumChannels-1:0]             ready_to_transfer_i,
  input  logic [NumChannels*GrantCntWidth-1:0] num_grants_i,
  xdma_grant_manager_mc_if.master            gnt_if,
  output logic [NumChannels-1:0]             chan_busy_o,
  output logic [NumChannels-1:0]             timeout_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PENDING     = 2'd1,
    WAIT_FINISH = 2'd2
  } state_e;

  state_e                   r_state [NumChannels];
  logic [GrantCntWidth-1:0] r_rem   [NumChannels];
  logic [ChanIdWidth-1:0]   r_ptr;
  logic                     r_locked;
  logic [ChanIdWidth-1:0]   r_lock_chan;

  logic [NumChannels-1:0]   w_live;
  logic [NumChannels-1:0]   w_need;
  logic [NumChannels-1:0]   w_req;
  logic [NumChannels-1:0]   w_hs_chan;
  logic [GrantCntWidth-1:0] w_num [NumChannels];
  logic                     w_rr_valid;
  logic [ChanIdWidth-1:0]   w_rr_chan;
  int unsigned              w_idx;
  logic                     w_valid;
  logic [ChanIdWidth-1:0]   w_sel;
  logic                     w_hs;

  assign w_live = ready_to_transfer_i & dma_type_i;
  assign w_need = w_live & ~is_first_cw_i;

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      w_num[c] = num_grants_i[c*GrantCntWidth +: GrantCntWidth];
      w_req[c] = (r_state[c] == PENDING) && w_live[c];
    end
  end

  // Round-robin search starting at r_ptr; first requester found wins.
  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_chan  = '0;
    w_idx      = 0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      w_idx = (32'(r_ptr) + i) % NumChannels;
      if (!w_rr_valid && w_req[w_idx]) begin
        w_rr_valid = 1'b1;
        w_rr_chan  = w_idx[ChanIdWidth-1:0];
      end
    end
  end

  // A locked offer is held until handshake; it only drops if the locked channel stops being live.
  assign w_valid = r_locked ? w_req[r_lock_chan] : w_rr_valid;
  assign w_sel   = r_locked ? r_lock_chan : w_rr_chan;
  assign w_hs    = w_valid & gnt_if.grant_ready_i;

  assign gnt_if.grant_valid_o = w_valid;
  assign gnt_if.grant_chan_o  = w_valid ? w_sel : '0;

  always_comb begin
    for (int unsigned c = 0; c < NumChannels; c++) begin
      w_hs_chan[c] = w_hs && (32'(w_sel) == c);
      chan_busy_o[c] = (r_state[c] != IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_locked    <= 1'b0;
      r_lock_chan <= '0;
    end else if (w_hs) begin
      r_ptr       <= (32'(w_sel) == NumChannels - 1) ? '0 : w_sel + 1'b1;
      r_locked    <= 1'b0;
    end else begin
      r_locked    <= w_valid;
      r_lock_chan <= w_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        r_state[c] <= IDLE;
        r_rem[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        case (r_state[c])
          IDLE: begin
            if (w_need[c]) begin
              r_state[c] <= PENDING;
              r_rem[c]   <= (w_num[c] == '0) ? GrantCntWidth'(1) : w_num[c];
            end
          end
          PENDING: begin
            if (!w_live[c]) begin
              r_state[c] <= IDLE;
              r_rem[c]   <= '0;
            end else if (w_hs_chan[c] && (r_rem[c] != '0)) begin
              r_rem[c] <= r_rem[c] - 1'b1;
              if (r_rem[c] == GrantCntWidth'(1)) r_state[c] <= WAIT_FINISH;
            end
          end
          WAIT_FINISH: begin
            if (!w_live[c]) r_state[c] <= IDLE;
          end
          default: r_state[c] <= IDLE;
        endcase
      end
    end
  end

`ifdef XDMA_GRANT_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TimeoutCycles);

  logic [StallW-1:0]      r_stall [NumChannels];
  logic [NumChannels-1:0] r_timeout;

  // Flag sets on the same edge the saturating counter reaches TimeoutCycles-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timeout <= '0;
      for (int unsigned c = 0; c < NumChannels; c++) r_stall[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NumChannels; c++) begin
        if ((r_state[c] == PENDING) && w_live[c] && !w_hs_chan[c]) begin
          if (r_stall[c] != StallW'(TimeoutCycles - 1)) r_stall[c] <= r_stall[c] + 1'b1;
          if (32'(r_stall[c]) >= TimeoutCycles - 2) r_timeout[c] <= 1'b1;
        end else begin
          r_stall[c] <= '0;
        end
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = '0;
`endif

endmodule
